// File: rtl/sta_sched_pkg.sv
// Shared state encoding and sizing helpers for the STA tile scheduler.
package sta_sched_pkg;

  localparam int SA_N = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_BIAS   = 3'd2,
    ST_FEED   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5,
    ST_RETIRE = 3'd6,
    ST_FINISH = 3'd7
  } sched_state_e;

  // Skewed operands need 2*(n-1) cycles to cross the array plus n to leave it.
  function automatic int drain_cycles(input int sa_n);
    return 3 * sa_n - 2;
  endfunction

endpackage

// File: rtl/sta_idle_filter.sv
// Qualifies sta_idle: o_hold_met is high on the HOLD-th consecutive idle cycle
// since the last clear or the last non-idle cycle.
module sta_idle_filter #(
  parameter int HOLD = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_idle,
  output logic o_hold_met
);

  localparam int CW = $clog2(HOLD + 1);

  logic [CW-1:0] r_remain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_remain <= CW'(HOLD - 1);
    end else if (i_clr || !i_idle) begin
      r_remain <= CW'(HOLD - 1);
    end else if (r_remain != '0) begin
      r_remain <= r_remain - CW'(1);
    end
  end

  assign o_hold_met = !i_clr && i_idle && (r_remain == '0);

endmodule

// File: rtl/sta_tile_scheduler.sv
// Walks SA_N x SA_N output tiles across one conv layer, sequencing clear, bias,
// operand feed and drain on the STA complex, then waiting for it to go idle.
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | reset_sta pulse for the new tile
// BIAS   | bias load, held off by stall
// FEED   | one operand step per non-stalled cycle
// DRAIN  | flush array skew
// DONE   | done pulse
// RETIRE | wait for IDLE_HOLD consecutive idle cycles, then advance
// FINISH | layer_done, back to IDLE
module sta_tile_scheduler
  import sta_sched_pkg::*;
#(
  parameter int MAX_N        = 64,
  parameter int N_BITS       = $clog2(MAX_N),
  parameter int SA_N         = sta_sched_pkg::SA_N,
  parameter int MAX_K        = 1024,
  parameter int K_BITS       = $clog2(MAX_K + 1),
  parameter int DRAIN_CYCLES = drain_cycles(SA_N),
  parameter int IDLE_HOLD    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [N_BITS:0]   i_cfg_out_rows,
  input  logic [N_BITS:0]   i_cfg_out_cols,
  input  logic [K_BITS-1:0] i_cfg_k_steps,
  input  logic [2:0]        i_cfg_layer_idx,
  input  logic              i_stall,
  input  logic              i_sta_idle,
  output logic              o_busy,
  output logic [2:0]        o_layer_idx,
  output logic [N_BITS-1:0] o_pos_row,
  output logic [N_BITS-1:0] o_pos_col,
  output logic              o_reset_sta,
  output logic              o_load_bias,
  output logic              o_feed_valid,
  output logic [K_BITS-1:0] o_feed_k_idx,
  output logic              o_done,
  output logic              o_layer_done
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  sched_state_e      r_state;
  logic [N_BITS:0]   r_rows;
  logic [N_BITS:0]   r_cols;
  logic [K_BITS-1:0] r_k_steps;
  logic [K_BITS-1:0] r_k;
  logic [K_BITS-1:0] r_feed_k_idx;
  logic [2:0]        r_layer_idx;
  logic [N_BITS-1:0] r_pos_row;
  logic [N_BITS-1:0] r_pos_col;
  logic [DW-1:0]     r_drain;
  logic              r_busy;
  logic              r_reset_sta;
  logic              r_load_bias;
  logic              r_feed_valid;
  logic              r_done;
  logic              r_layer_done;

  logic [N_BITS:0]   w_next_col;
  logic [N_BITS:0]   w_next_row;
  logic              w_col_fits;
  logic              w_row_fits;
  logic              w_last_feed;
  logic              w_abort;
  logic              w_idle_clr;
  logic              w_hold_met;

  // Compared one bit wider than the position so a full 64-wide map cannot wrap.
  assign w_next_col  = {1'b0, r_pos_col} + (N_BITS+1)'(SA_N);
  assign w_next_row  = {1'b0, r_pos_row} + (N_BITS+1)'(SA_N);
  assign w_col_fits  = w_next_col < r_cols;
  assign w_row_fits  = w_next_row < r_rows;
  assign w_last_feed = (r_k + K_BITS'(1)) == r_k_steps;
  assign w_abort     = i_abort && (r_state != ST_IDLE) && (r_state != ST_FINISH);
  assign w_idle_clr  = r_state != ST_RETIRE;

  sta_idle_filter #(
    .HOLD (IDLE_HOLD)
  ) u_idle_filter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_idle_clr),
    .i_idle     (i_sta_idle),
    .o_hold_met (w_hold_met)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_rows       <= '0;
      r_cols       <= '0;
      r_k_steps    <= '0;
      r_k          <= '0;
      r_feed_k_idx <= '0;
      r_layer_idx  <= '0;
      r_pos_row    <= '0;
      r_pos_col    <= '0;
      r_drain      <= '0;
      r_busy       <= 1'b0;
      r_reset_sta  <= 1'b0;
      r_load_bias  <= 1'b0;
      r_feed_valid <= 1'b0;
      r_done       <= 1'b0;
      r_layer_done <= 1'b0;
    end else begin
      r_reset_sta  <= 1'b0;
      r_load_bias  <= 1'b0;
      r_feed_valid <= 1'b0;
      r_done       <= 1'b0;
      r_layer_done <= 1'b0;
      if (w_abort) begin
        r_reset_sta <= 1'b1;
        r_state     <= ST_FINISH;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              r_rows      <= i_cfg_out_rows;
              r_cols      <= i_cfg_out_cols;
              r_k_steps   <= i_cfg_k_steps;
              r_layer_idx <= i_cfg_layer_idx;
              r_busy      <= 1'b1;
              r_pos_row   <= '0;
              r_pos_col   <= '0;
              if (i_cfg_out_rows == '0 || i_cfg_out_cols == '0) begin
                r_state <= ST_FINISH;
              end else begin
                r_reset_sta <= 1'b1;
                r_state     <= ST_CLEAR;
              end
            end
          end
          ST_CLEAR: r_state <= ST_BIAS;
          ST_BIAS: begin
            if (!i_stall) begin
              r_load_bias <= 1'b1;
              r_k         <= '0;
              if (r_k_steps == '0) begin
                r_drain <= DW'(DRAIN_CYCLES);
                r_state <= ST_DRAIN;
              end else begin
                r_state <= ST_FEED;
              end
            end
          end
          ST_FEED: begin
            // The index is shown even while stalled so the pending step is visible.
            r_feed_k_idx <= r_k;
            if (!i_stall) begin
              r_feed_valid <= 1'b1;
              r_k          <= r_k + K_BITS'(1);
              if (w_last_feed) begin
                r_drain <= DW'(DRAIN_CYCLES);
                r_state <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: begin
            if (!i_stall) begin
              if (r_drain == DW'(1)) begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_drain <= r_drain - DW'(1);
              end
            end
          end
          ST_DONE: r_state <= ST_RETIRE;
          ST_RETIRE: begin
            if (w_hold_met) begin
              if (w_col_fits) begin
                r_pos_col   <= w_next_col[N_BITS-1:0];
                r_reset_sta <= 1'b1;
                r_state     <= ST_CLEAR;
              end else if (w_row_fits) begin
                r_pos_col   <= '0;
                r_pos_row   <= w_next_row[N_BITS-1:0];
                r_reset_sta <= 1'b1;
                r_state     <= ST_CLEAR;
              end else begin
                r_state <= ST_FINISH;
              end
            end
          end
          ST_FINISH: begin
            r_busy       <= 1'b0;
            r_layer_done <= 1'b1;
            r_state      <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_busy       = r_busy;
  assign o_layer_idx  = r_layer_idx;
  assign o_pos_row    = r_pos_row;
  assign o_pos_col    = r_pos_col;
  assign o_reset_sta  = r_reset_sta;
  assign o_load_bias  = r_load_bias;
  assign o_feed_valid = r_feed_valid;
  assign o_feed_k_idx = r_feed_k_idx;
  assign o_done       = r_done;
  assign o_layer_done = r_layer_done;

endmodule

// File: tb/tb_sta_tile_scheduler.sv
// Directed bench for sta_tile_scheduler: tile walk, feed/drain timing, stalls,
// retire idle qualification, abort, degenerate configs and async reset.
module tb_sta_tile_scheduler;

  localparam int N_BITS = 6;
  localparam int K_BITS = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [N_BITS:0]   cfg_rows = '0;
  logic [N_BITS:0]   cfg_cols = '0;
  logic [K_BITS-1:0] cfg_k = '0;
  logic [2:0]        cfg_lidx = '0;
  logic              stall = 1'b0;
  logic              sta_idle = 1'b1;

  logic              busy, reset_sta, load_bias, feed_valid, done, layer_done;
  logic [2:0]        layer_idx;
  logic [N_BITS-1:0] pos_row, pos_col;
  logic [K_BITS-1:0] feed_k_idx;

  always #5 clk = ~clk;

  sta_tile_scheduler dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (start),
    .i_abort         (abort),
    .i_cfg_out_rows  (cfg_rows),
    .i_cfg_out_cols  (cfg_cols),
    .i_cfg_k_steps   (cfg_k),
    .i_cfg_layer_idx (cfg_lidx),
    .i_stall         (stall),
    .i_sta_idle      (sta_idle),
    .o_busy          (busy),
    .o_layer_idx     (layer_idx),
    .o_pos_row       (pos_row),
    .o_pos_col       (pos_col),
    .o_reset_sta     (reset_sta),
    .o_load_bias     (load_bias),
    .o_feed_valid    (feed_valid),
    .o_feed_k_idx    (feed_k_idx),
    .o_done          (done),
    .o_layer_done    (layer_done)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_feed, n_done, n_clear, n_bias, n_ldone;
  int idx_seq, idx_err, last_feed_cyc, last_bias_cyc;
  logic [11:0] done_pos[$];
  int done_gap[$];
  int bias_gap[$];
  int tile_feeds[$];
  logic [11:0] exp_pos [4];
  int pat [7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_feed = 0; n_done = 0; n_clear = 0; n_bias = 0; n_ldone = 0;
    idx_seq = 0; idx_err = 0; last_feed_cyc = 0; last_bias_cyc = 0;
    done_pos.delete(); done_gap.delete(); bias_gap.delete(); tile_feeds.delete();
  endtask

  // Advance one clock and tally the pulses seen just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (reset_sta) begin n_clear++; idx_seq = 0; end
    if (load_bias) begin n_bias++; last_bias_cyc = cyc; end
    if (feed_valid) begin
      if (int'(feed_k_idx) != idx_seq) idx_err++;
      idx_seq++; n_feed++; last_feed_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_pos.push_back({pos_row, pos_col});
      done_gap.push_back(cyc - last_feed_cyc);
      bias_gap.push_back(cyc - last_bias_cyc);
      tile_feeds.push_back(idx_seq);
    end
    if (layer_done) n_ldone++;
  endtask

  task automatic start_layer(input int rows, input int cols, input int k, input int lidx);
    clear_stats();
    cfg_rows = 7'(rows); cfg_cols = 7'(cols); cfg_k = 11'(k); cfg_lidx = 3'(lidx);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_layer_done(input int limit, input string tag);
    int n = 0;
    while (!layer_done && n < limit) begin step(); n++; end
    chk(tag, 32'(layer_done), 1);
  endtask

  task automatic wait_done(input int limit, input string tag);
    int n = 0;
    while (!done && n < limit) begin step(); n++; end
    chk(tag, 32'(done), 1);
  endtask

  task automatic wait_feed(input int idx, input int limit, input string tag);
    int n = 0;
    while (!(feed_valid && int'(feed_k_idx) == idx) && n < limit) begin step(); n++; end
    chk(tag, 32'(feed_valid), 1);
  endtask

  initial begin
    exp_pos = '{12'd0, 12'd4, 12'd256, 12'd260};
    pat = '{1, 1, 0, 1, 1, 1, 1};
    clear_stats();

    // reset state
    step(); step();
    chk("reset_outs", {busy, reset_sta, load_bias, feed_valid, done, layer_done,
                       layer_idx, pos_row, pos_col, feed_k_idx}, 0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 0);

    // 8x8, k=9: four tiles, start while busy ignored
    start_layer(8, 8, 9, 2);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_clear", 32'(reset_sta), 1);
    chk("t1_pos0", {pos_row, pos_col}, 0);
    chk("t1_lidx", 32'(layer_idx), 2);
    repeat (5) step();
    cfg_rows = '0; cfg_lidx = 3'd6; start = 1'b1;
    step();
    start = 1'b0;
    wait_layer_done(400, "t1_layer_done");
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_lidx_kept", 32'(layer_idx), 2);
    chk("t1_ndone", 32'(n_done), 4);
    chk("t1_nfeed", 32'(n_feed), 36);
    chk("t1_nclear", 32'(n_clear), 4);
    chk("t1_nbias", 32'(n_bias), 4);
    chk("t1_idx_err", 32'(idx_err), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_pos%0d", i), 32'(done_pos[i]), 32'(exp_pos[i]));
      chk($sformatf("t1_feeds%0d", i), 32'(tile_feeds[i]), 9);
      chk($sformatf("t1_gap%0d", i), 32'(done_gap[i]), 10);
    end
    step();
    chk("t1_ldone_pulse", 32'(layer_done), 0);
    chk("t1_pos_held", {pos_row, pos_col}, 260);
    chk("t1_nldone", 32'(n_ldone), 1);

    // 6x5, k=2: partial edge tiles
    start_layer(6, 5, 2, 5);
    wait_layer_done(300, "t2_layer_done");
    chk("t2_ndone", 32'(n_done), 4);
    chk("t2_last_pos", 32'(done_pos[3]), 260);
    chk("t2_nfeed", 32'(n_feed), 8);
    chk("t2_busy", 32'(busy), 0);
    step();
    chk("t2_busy_after", 32'(busy), 0);

    // stall during FEED at k=4
    start_layer(4, 4, 9, 0);
    wait_feed(3, 50, "t3_reach_k3");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t3_stall_valid%0d", i), 32'(feed_valid), 0);
      chk($sformatf("t3_stall_idx%0d", i), 32'(feed_k_idx), 4);
    end
    stall = 1'b0;
    step();
    chk("t3_resume", {31'd0, feed_valid} + 32'(feed_k_idx) * 2, 9);
    wait_layer_done(100, "t3_layer_done");
    chk("t3_nfeed", 32'(n_feed), 9);
    chk("t3_idx_err", 32'(idx_err), 0);
    chk("t3_gap", 32'(done_gap[0]), 10);

    // stall during DRAIN freezes the drain count
    start_layer(4, 4, 9, 0);
    wait_feed(8, 50, "t3b_last_feed");
    step(); step();
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    wait_layer_done(100, "t3b_layer_done");
    chk("t3b_nfeed", 32'(n_feed), 9);
    chk("t3b_gap", 32'(done_gap[0]), 13);

    // RETIRE only advances after IDLE_HOLD consecutive idle cycles
    start_layer(4, 8, 1, 0);
    wait_done(60, "t4_done");
    sta_idle = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      sta_idle = pat[i][0];
      step();
      if (i < 6) begin
        chk($sformatf("t4_hold%0d", i), {reset_sta, 6'(pos_col)}, 0);
      end else begin
        chk("t4_advance", {reset_sta, 6'(pos_col)}, 32'h44);
      end
    end
    sta_idle = 1'b1;
    wait_layer_done(100, "t4_layer_done");
    chk("t4_ndone", 32'(n_done), 2);

    // abort mid-FEED, then restart with start and abort together
    start_layer(8, 8, 9, 1);
    wait_feed(4, 50, "t5_reach_k4");
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_abort_clear", {reset_sta, feed_valid, layer_done}, 3'b100);
    step();
    chk("t5_layer_done", {layer_done, busy}, 2'b10);
    chk("t5_no_done", 32'(n_done), 0);
    clear_stats();
    cfg_rows = 7'd4; cfg_cols = 7'd4; cfg_k = 11'd2; cfg_lidx = 3'd7;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("t5_restart", {busy, reset_sta, layer_idx, pos_row, pos_col}, {2'b11, 3'd7, 12'd0});
    wait_layer_done(100, "t5_layer_done2");
    chk("t5_ndone2", 32'(n_done), 1);

    // k=0: BIAS goes straight to DRAIN
    start_layer(4, 4, 0, 0);
    wait_layer_done(100, "t6_layer_done");
    chk("t6_nfeed", 32'(n_feed), 0);
    chk("t6_ndone", 32'(n_done), 1);
    chk("t6_nbias", 32'(n_bias), 1);
    chk("t6_bias_gap", 32'(bias_gap[0]), 10);

    // rows=0: immediate layer_done, no tile
    start_layer(0, 8, 5, 4);
    chk("t7_busy", {busy, reset_sta}, 2'b10);
    step();
    chk("t7_layer_done", {layer_done, busy}, 2'b10);
    chk("t7_nclear", 32'(n_clear), 0);

    // async reset mid-layer
    start_layer(8, 8, 9, 3);
    repeat (40) step();
    chk("t8_second_tile", 32'(pos_col), 4);
    rst_n = 1'b0;
    #1;
    chk("t8_reset_outs", {busy, reset_sta, load_bias, feed_valid, done, layer_done,
                          layer_idx, pos_row, pos_col, feed_k_idx}, 0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("t8_no_layer_done", 32'(n_ldone), 0);
    chk("t8_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
